// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUOp values, the 5-bit
// extended ALU control, FSM states and the control decoder.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  localparam logic [1:0] ALUOP_ILL = 2'b11;

  localparam logic [4:0] ALUCTL_ADD    = 5'd0;
  localparam logic [4:0] ALUCTL_SUB    = 5'd1;
  localparam logic [4:0] ALUCTL_SLL    = 5'd2;
  localparam logic [4:0] ALUCTL_SLT    = 5'd3;
  localparam logic [4:0] ALUCTL_SLTU   = 5'd4;
  localparam logic [4:0] ALUCTL_XOR    = 5'd5;
  localparam logic [4:0] ALUCTL_SRL    = 5'd6;
  localparam logic [4:0] ALUCTL_SRA    = 5'd7;
  localparam logic [4:0] ALUCTL_OR     = 5'd8;
  localparam logic [4:0] ALUCTL_AND    = 5'd9;
  // M group is {2'b10, fn3}: bits [4:2] = 100 multiply, 101 divide/remainder;
  // inside the divide half, bit 0 = unsigned and bit 1 = remainder.
  localparam logic [4:0] ALUCTL_MUL    = 5'd16;
  localparam logic [4:0] ALUCTL_MULH   = 5'd17;
  localparam logic [4:0] ALUCTL_MULHSU = 5'd18;
  localparam logic [4:0] ALUCTL_MULHU  = 5'd19;
  localparam logic [4:0] ALUCTL_DIV    = 5'd20;
  localparam logic [4:0] ALUCTL_DIVU   = 5'd21;
  localparam logic [4:0] ALUCTL_REM    = 5'd22;
  localparam logic [4:0] ALUCTL_REMU   = 5'd23;
  localparam logic [4:0] ALUCTL_ILL    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } alu_state_e;

  // Map ALUOp/funct fields to the extended control; unsupported -> ALUCTL_ILL.
  function automatic logic [4:0] alu_decode(input logic [1:0] aluop, input logic [2:0] fn3,
                                            input logic [6:0] fn7, input logic op,
                                            input logic m_en);
    logic [4:0] ctl;
    ctl = ALUCTL_ILL;
    case (aluop)
      ALUOP_ADD: ctl = ALUCTL_ADD;
      ALUOP_SUB: ctl = ALUCTL_SUB;
      ALUOP_FN: begin
        if (op && fn7 == 7'b0000001) begin
          ctl = m_en ? {2'b10, fn3} : ALUCTL_ILL;
        end else begin
          case (fn3)
            3'b000:  ctl = (op && fn7[5]) ? ALUCTL_SUB : ALUCTL_ADD;
            3'b001:  ctl = ALUCTL_SLL;
            3'b010:  ctl = ALUCTL_SLT;
            3'b011:  ctl = ALUCTL_SLTU;
            3'b100:  ctl = ALUCTL_XOR;
            3'b101:  ctl = fn7[5] ? ALUCTL_SRA : ALUCTL_SRL;
            3'b110:  ctl = ALUCTL_OR;
            default: ctl = ALUCTL_AND;
          endcase
        end
      end
      default: ctl = ALUCTL_ILL;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/exec_alu_unit_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, XLEN iterations.
// done is high during the final iteration; quotient/remainder are valid from
// the following cycle until the next start.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;

  assign done = busy & (cnt == CW'(XLEN - 1));

  // Trial subtraction; a set top bit means the shifted remainder was smaller.
  always_comb begin
    shifted = {remainder, quotient[XLEN-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  // Iteration registers: quotient doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy      <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= '0;
      quotient  <= dividend;
      remainder <= '0;
      dvsr      <= divisor;
    end else if (busy) begin
      quotient  <= {quotient[XLEN-2:0], ~trial[XLEN]};
      remainder <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      cnt       <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage unit: decodes ALUOp/fn3/fn7/op, runs RV32I ops in one cycle,
// multiplies through a MUL_STAGES pipeline and divides iteratively.
//
// Handshake: an op is taken on in_valid & in_ready (operands and control are
// captured then); result/illegal stay stable while out_valid=1 and are
// released on out_valid & out_ready. flush voids both handshakes that cycle.
module exec_alu_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit M_EN       = 1'b1,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      fn3,
  input  logic [6:0]      fn7,
  input  logic            op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [1:0]      dbg_state
);
  localparam int SW       = $clog2(XLEN);
  localparam bit MUL_PIPE = (MUL_STAGES > 1);
  localparam int PD       = MUL_PIPE ? MUL_STAGES - 1 : 1;
  localparam int MCW      = MUL_PIPE ? $clog2(MUL_STAGES) : 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      state_q, state_d;
  logic [4:0]      ctl;
  logic            accept, fire;
  logic            is_mul, is_div, div_signed, div_is_rem, div_special, long_div;
  logic            a_neg, b_neg, sa, sb, mul_hi_in;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res, quick_res, mag_a, mag_b, fix_res;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mul_pipe [PD];
  logic [MCW-1:0]  mul_cnt;
  logic            mul_hi, neg_q, neg_r, rem_sel;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  assign in_ready  = ~rst & ~flush & (state_q == ST_IDLE) & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready & ~flush;
  assign dbg_state = state_q;

  // Decode and all single-cycle results, including divide special cases.
  always_comb begin
    ctl         = alu_decode(ALUOp, fn3, fn7, op, M_EN);
    is_mul      = (ctl[4:2] == 3'b100);
    is_div      = (ctl[4:2] == 3'b101);
    div_signed  = ~ctl[0];
    div_is_rem  = ctl[1];
    a_neg       = div_signed & src_a[XLEN-1];
    b_neg       = div_signed & src_b[XLEN-1];
    mag_a       = a_neg ? -src_a : src_a;
    mag_b       = b_neg ? -src_b : src_b;
    div_special = (src_b == '0) | (div_signed & (src_a == XMIN) & (src_b == '1));
    long_div    = is_div & ~div_special;
    shamt       = src_b[SW-1:0];
    sa          = (ctl == ALUCTL_MULH) || (ctl == ALUCTL_MULHSU);
    sb          = (ctl == ALUCTL_MULH);
    mul_hi_in   = (ctl != ALUCTL_MUL);
    prod        = {{XLEN{sa & src_a[XLEN-1]}}, src_a} * {{XLEN{sb & src_b[XLEN-1]}}, src_b};
    alu_res     = '0;
    case (ctl)
      ALUCTL_ADD:  alu_res = src_a + src_b;
      ALUCTL_SUB:  alu_res = src_a - src_b;
      ALUCTL_SLL:  alu_res = src_a << shamt;
      ALUCTL_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALUCTL_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALUCTL_XOR:  alu_res = src_a ^ src_b;
      ALUCTL_SRL:  alu_res = src_a >> shamt;
      ALUCTL_SRA:  alu_res = $signed(src_a) >>> shamt;
      ALUCTL_OR:   alu_res = src_a | src_b;
      ALUCTL_AND:  alu_res = src_a & src_b;
      default:     alu_res = '0;
    endcase
    if (ctl == ALUCTL_ILL)     quick_res = '0;
    else if (is_div)           quick_res = (src_b == '0) ? (div_is_rem ? src_a : '1)
                                                         : (div_is_rem ? '0 : XMIN);
    else if (is_mul)           quick_res = mul_hi_in ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else                       quick_res = alu_res;
    fix_res = rem_sel ? (neg_r ? -div_rem : div_rem) : (neg_q ? -div_quo : div_quo);
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (accept & long_div),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul && MUL_PIPE) state_d = ST_MUL;
        else if (accept && long_div)      state_d = ST_DIV;
      end
      ST_MUL:  if (mul_cnt == MCW'(1)) state_d = ST_IDLE;
      ST_DIV: begin
        if (div_done)       state_d = ST_FIX;
        else if (!div_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Result/output registers, multiply pipeline and divide sign bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      mul_cnt   <= '0;
      mul_hi    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      rem_sel   <= 1'b0;
      for (int i = 0; i < PD; i++) mul_pipe[i] <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (fire) out_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul && MUL_PIPE) begin
              mul_pipe[0] <= prod;
              mul_hi      <= mul_hi_in;
              mul_cnt     <= MCW'(MUL_STAGES - 1);
            end else if (long_div) begin
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= a_neg;
              rem_sel <= div_is_rem;
            end else begin
              result    <= quick_res;
              illegal   <= (ctl == ALUCTL_ILL);
              out_valid <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          for (int i = 1; i < PD; i++) mul_pipe[i] <= mul_pipe[i-1];
          mul_cnt <= mul_cnt - MCW'(1);
          if (mul_cnt == MCW'(1)) begin
            result    <= mul_hi ? mul_pipe[PD-1][2*XLEN-1:XLEN] : mul_pipe[PD-1][XLEN-1:0];
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_FIX: begin
          result    <= fix_res;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
